// File: rtl/decode_skid_stage.sv
// Purpose: decode stage; splits {pc, instr} into fields and classifies its format into a 2-entry skid buffer.
// Latency: an entry pushed at edge N is presented with o_out_valid=1 after edge N; sustains 1 entry/cycle.
// Backpressure: o_in_ready=(count<2) from registered state only; o_out_ready=0 holds the head stable.
module decode_skid_stage #(
  parameter int PC_W  = 12,
  parameter int DEPTH = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [PC_W-1:0] i_in_pc,
  input  logic [31:0]     i_in_instr,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [PC_W-1:0] o_out_pc,
  output logic [4:0]      o_opcode,
  output logic [4:0]      o_rd,
  output logic [4:0]      o_rs,
  output logic [4:0]      o_rt,
  output logic [4:0]      o_shamt,
  output logic [4:0]      o_aluop,
  output logic [16:0]     o_imm_raw,
  output logic [26:0]     o_target,
  output logic [1:0]      o_fmt,
  output logic            o_illegal
);

  // The pointer and count logic below only works for two entries.
  if (DEPTH != 2) begin : g_bad_depth
    $error("decode_skid_stage: DEPTH must be 2");
  end

  localparam logic [1:0] FMT_R   = 2'd0;
  localparam logic [1:0] FMT_I   = 2'd1;
  localparam logic [1:0] FMT_JI  = 2'd2;
  localparam logic [1:0] FMT_JII = 2'd3;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
    logic [1:0]      fmt;
    logic            illegal;
  } entry_t;

  entry_t      r_mem [0:1];
  logic        r_head;
  logic        r_tail;
  logic [1:0]  r_count;
  logic        r_last;

  logic        w_push;
  logic        w_pop;
  logic        w_show;
  logic [1:0]  w_fmt;
  logic        w_illegal;
  entry_t      w_entry;
  entry_t      w_head;

  assign o_in_ready  = (r_count < 2'd2);
  assign o_out_valid = (r_count != 2'd0);
  assign w_push      = i_in_valid & o_in_ready;
  assign w_pop       = o_out_valid & i_out_ready;

  // Classify the incoming opcode; unknown opcodes travel as R-format flagged illegal.
  always_comb begin
    w_fmt     = FMT_R;
    w_illegal = 1'b0;
    case (i_in_instr[31:27])
      5'b00000:                                   w_fmt = FMT_R;
      5'b00101, 5'b00111, 5'b01000,
      5'b00010, 5'b00110:                         w_fmt = FMT_I;
      5'b00001, 5'b00011, 5'b10101, 5'b10110:     w_fmt = FMT_JI;
      5'b00100:                                   w_fmt = FMT_JII;
      default: begin
        w_fmt     = FMT_R;
        w_illegal = 1'b1;
      end
    endcase
  end

  assign w_entry = '{pc: i_in_pc, instr: i_in_instr, fmt: w_fmt, illegal: w_illegal};

  // When empty, keep showing the slot that was last presented so fields hold their value.
  assign w_show = o_out_valid ? r_head : r_last;
  assign w_head = r_mem[w_show];

  // Buffer state: flush squashes pointers/count and any same-cycle push or pop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_mem[i] <= '0;
      end
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= 2'd0;
      r_last  <= 1'b0;
    end else begin
      r_last <= w_show;
      if (i_flush) begin
        r_head  <= 1'b0;
        r_tail  <= 1'b0;
        r_count <= 2'd0;
      end else begin
        if (w_push) begin
          r_mem[r_tail] <= w_entry;
          r_tail        <= ~r_tail;
        end
        if (w_pop) begin
          r_head <= ~r_head;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 2'd1;
          2'b01:   r_count <= r_count - 2'd1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  assign o_out_pc  = w_head.pc;
  assign o_opcode  = w_head.instr[31:27];
  assign o_rd      = w_head.instr[26:22];
  assign o_rs      = w_head.instr[21:17];
  assign o_rt      = w_head.instr[16:12];
  assign o_shamt   = w_head.instr[11:7];
  assign o_aluop   = w_head.instr[6:2];
  assign o_imm_raw = w_head.instr[16:0];
  assign o_target  = w_head.instr[26:0];
  assign o_fmt     = w_head.fmt;
  assign o_illegal = w_head.illegal;

endmodule
